// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter and the memory block it
// feeds: default bus widths and the arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package dmem_pkg;

    // Default widths, shared with the data-memory block.
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Arbiter FSM states.
    //   ST_IDLE    : no host request pending.
    //   ST_WAIT    : host request pending and denied; wait counter running.
    //   ST_HOLDOFF : one cycle after a forced host grant; host cannot be forced.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the three sides of the data-memory arbiter:
//   CPU  : cpu_ld, cpu_store, cpu_rd_addr, cpu_wr_addr, cpu_wr_data,
//          cpu_rd_data, cpu_stall
//   Host : host_req, host_we, host_addr, host_wdata, host_gnt,
//          host_rdata, host_valid
//   Mem  : data_rd_addr, data_wr_addr, datamem_wr_data, store_to_mem,
//          datamem_rd_data
// Modports:
//   slave  : the arbiter (receives CPU/host requests, drives the memory).
//   master : the surroundings (CPU, host and memory models).
// Handshake: host_req is a level request held until host_gnt; a cycle with
// host_req & host_gnt is exactly one completed access. A CPU access is
// completed in every cycle where cpu_ld|cpu_store is high and cpu_stall is low.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // CPU side
    logic              cpu_ld;
    logic              cpu_store;
    logic [ADDR_W-1:0] cpu_rd_addr;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              cpu_stall;

    // Host side
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_valid;

    // Memory side
    logic [ADDR_W-1:0] data_rd_addr;
    logic [ADDR_W-1:0] data_wr_addr;
    logic [DATA_W-1:0] datamem_wr_data;
    logic              store_to_mem;
    logic [DATA_W-1:0] datamem_rd_data;

    modport slave (
        input  cpu_ld, cpu_store, cpu_rd_addr, cpu_wr_addr, cpu_wr_data,
        output cpu_rd_data, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_valid,
        output data_rd_addr, data_wr_addr, datamem_wr_data, store_to_mem,
        input  datamem_rd_data
    );

    modport master (
        output cpu_ld, cpu_store, cpu_rd_addr, cpu_wr_addr, cpu_wr_data,
        input  cpu_rd_data, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_valid,
        input  data_rd_addr, data_wr_addr, datamem_wr_data, store_to_mem,
        output datamem_rd_data
    );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory port (async read, clocked write) between the CPU
// load/store path and a host port. The CPU wins by default; a wait counter
// forces a host grant after STARVE_LIMIT denied cycles, and a one-cycle
// holdoff after a forced grant lets the CPU through before the host can be
// forced again.
// Ports:
//   clk            : system clock, all state on posedge.
//   reset          : synchronous, active-high.
//   bus            : dmem_arbiter_if.slave (CPU, host and memory signals).
//   o_dbg_state    : current FSM state.
//   o_dbg_wait_cnt : current wait counter.
// STARVE_LIMIT must lie in 1..15 (the counter is 4 bits).
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_arbiter_if.slave        bus,
    output state_t               o_dbg_state,
    output logic [3:0]           o_dbg_wait_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_next_cnt;
    logic [DATA_W-1:0] r_host_rdata;
    logic              r_host_valid;

    logic              w_cpu_act;
    logic              w_force_ok;
    logic              w_host_gnt;
    logic              w_forced;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_store;

    // Grant decision is purely combinational within the cycle. Forcing is
    // only possible from WAIT with a full count, so HOLDOFF never forces.
    assign w_cpu_act  = bus.cpu_ld | bus.cpu_store;
    assign w_force_ok = (r_state == ST_WAIT) && (r_wait_cnt == LIMIT);
    assign w_host_gnt = bus.host_req & ~reset & (~w_cpu_act | w_force_ok);
    // A grant while the CPU is active can only have come from forcing.
    assign w_forced   = w_host_gnt & w_cpu_act;

    // Memory port mux: host path only on a grant, CPU path otherwise
    // (including throughout reset, since the grant is masked by reset).
    always_comb begin
        w_rd_addr = bus.cpu_rd_addr;
        w_wr_addr = bus.cpu_wr_addr;
        w_wr_data = bus.cpu_wr_data;
        w_store   = bus.cpu_store;
        if (w_host_gnt) begin
            w_rd_addr = bus.host_addr;
            w_wr_addr = bus.host_addr;
            w_wr_data = bus.host_wdata;
            w_store   = bus.host_we;
        end
    end

    assign bus.data_rd_addr    = w_rd_addr;
    assign bus.data_wr_addr    = w_wr_addr;
    assign bus.datamem_wr_data = w_wr_data;
    assign bus.store_to_mem    = w_store;
    assign bus.cpu_rd_data     = bus.datamem_rd_data;
    assign bus.cpu_stall       = w_forced;
    assign bus.host_gnt        = w_host_gnt;
    assign bus.host_rdata      = r_host_rdata;
    // Masked by reset so a read granted just before reset never reports.
    assign bus.host_valid      = r_host_valid & ~reset;

    assign o_dbg_state    = r_state;
    assign o_dbg_wait_cnt = r_wait_cnt;

    // Next-state and wait-counter logic.
    always_comb begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
        case (r_state)
            ST_IDLE, ST_HOLDOFF: begin
                // HOLDOFF lasts one cycle; a denied request restarts counting.
                if (bus.host_req && !w_host_gnt) begin
                    w_next_state = ST_WAIT;
                    w_next_cnt   = 4'd1;
                end
            end
            ST_WAIT: begin
                if (!bus.host_req) begin
                    // Request withdrawn: pending count is discarded.
                    w_next_state = ST_IDLE;
                end else if (w_host_gnt) begin
                    w_next_state = w_forced ? ST_HOLDOFF : ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT;
                    w_next_cnt   = (r_wait_cnt >= LIMIT) ? LIMIT : r_wait_cnt + 4'd1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= 4'd0;
            r_host_rdata <= '0;
            r_host_valid <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_wait_cnt   <= w_next_cnt;
            r_host_valid <= w_host_gnt & ~bus.host_we;
            if (w_host_gnt && !bus.host_we) begin
                r_host_rdata <= bus.datamem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter: a cycle-by-cycle vector table followed by
// hand-written sequences for request withdrawal and reset corner cases.
// Inputs change on the falling edge; outputs are compared 2 ns later.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam logic [1:0] SI = 2'd0;
    localparam logic [1:0] SW = 2'd1;
    localparam logic [1:0] SH = 2'd2;

    logic       clk;
    logic       reset;
    state_t     dbg_state;
    logic [3:0] dbg_cnt;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .o_dbg_state    (dbg_state),
        .o_dbg_wait_cnt (dbg_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0] mem [256];
    assign bus.datamem_rd_data = mem[bus.data_rd_addr];
    always @(posedge clk) begin
        if (bus.store_to_mem) mem[bus.data_wr_addr] <= bus.datamem_wr_data;
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic ld, input logic st, input logic [7:0] rda,
                         input logic [7:0] wra, input logic [7:0] wd,
                         input logic hreq, input logic hwe, input logic [7:0] ha,
                         input logic [7:0] hwd);
        bus.cpu_ld      = ld;
        bus.cpu_store   = st;
        bus.cpu_rd_addr = rda;
        bus.cpu_wr_addr = wra;
        bus.cpu_wr_data = wd;
        bus.host_req    = hreq;
        bus.host_we     = hwe;
        bus.host_addr   = ha;
        bus.host_wdata  = hwd;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       ld, st;
        logic [7:0] rda, wra, wd;
        logic       hreq, hwe;
        logic [7:0] ha, hwd;
        logic       e_gnt, e_stall, e_store;
        logic [7:0] e_rda, e_wra, e_wd;
        logic       chk_crd;
        logic [7:0] e_crd;
        logic       e_valid;
        logic [7:0] e_rdata;
        logic [1:0] e_state;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic fill_table();
        // CPU store A5 -> 10
        vecs.push_back('{0,1,8'h10,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,1,8'h10,8'h10,8'hA5, 0,8'h00, 0,8'h00, SI,0});
        // host read 10, CPU idle: immediate grant
        vecs.push_back('{0,0,8'h10,8'h00,8'h00, 1,0,8'h10,8'h00, 1,0,0,8'h10,8'h10,8'h00, 1,8'hA5, 0,8'h00, SI,0});
        vecs.push_back('{0,0,8'h10,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10,8'h00,8'h00, 1,8'hA5, 1,8'hA5, SI,0});
        // host write 77 -> 05, then CPU load 05
        vecs.push_back('{0,0,8'h05,8'h00,8'h00, 1,1,8'h05,8'h77, 1,0,1,8'h05,8'h05,8'h77, 0,8'h00, 0,8'hA5, SI,0});
        vecs.push_back('{1,0,8'h05,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h05,8'h00,8'h00, 1,8'h77, 0,8'hA5, SI,0});
        // three back-to-back host reads with CPU idle
        vecs.push_back('{0,0,8'h00,8'h00,8'h00, 1,0,8'h10,8'h00, 1,0,0,8'h10,8'h10,8'h00, 1,8'hA5, 0,8'hA5, SI,0});
        vecs.push_back('{0,0,8'h00,8'h00,8'h00, 1,0,8'h05,8'h00, 1,0,0,8'h05,8'h05,8'h00, 1,8'h77, 1,8'hA5, SI,0});
        vecs.push_back('{0,0,8'h00,8'h00,8'h00, 1,0,8'h10,8'h00, 1,0,0,8'h10,8'h10,8'h00, 1,8'hA5, 1,8'h77, SI,0});
        vecs.push_back('{0,0,8'h10,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10,8'h00,8'h00, 1,8'hA5, 1,8'hA5, SI,0});
        // CPU stores 3C -> 20 every cycle, host read 20: 4 denials then forced
        vecs.push_back('{0,1,8'h20,8'h20,8'h3C, 1,0,8'h20,8'h00, 0,0,1,8'h20,8'h20,8'h3C, 0,8'h00, 0,8'hA5, SI,0});
        vecs.push_back('{0,1,8'h20,8'h20,8'h3C, 1,0,8'h20,8'h00, 0,0,1,8'h20,8'h20,8'h3C, 1,8'h3C, 0,8'hA5, SW,1});
        vecs.push_back('{0,1,8'h20,8'h20,8'h3C, 1,0,8'h20,8'h00, 0,0,1,8'h20,8'h20,8'h3C, 1,8'h3C, 0,8'hA5, SW,2});
        vecs.push_back('{0,1,8'h20,8'h20,8'h3C, 1,0,8'h20,8'h00, 0,0,1,8'h20,8'h20,8'h3C, 1,8'h3C, 0,8'hA5, SW,3});
        vecs.push_back('{0,1,8'h20,8'h20,8'h3C, 1,0,8'h20,8'h00, 1,1,0,8'h20,8'h20,8'h00, 1,8'h3C, 0,8'hA5, SW,4});
        // HOLDOFF: CPU serviced
        vecs.push_back('{0,1,8'h20,8'h20,8'h3C, 0,0,8'h00,8'h00, 0,0,1,8'h20,8'h20,8'h3C, 1,8'h3C, 1,8'h3C, SH,0});
        vecs.push_back('{0,0,8'h20,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h20,8'h00,8'h00, 1,8'h3C, 0,8'h3C, SI,0});
        // forced host write 44 -> 31 while CPU stores 11 -> 30
        vecs.push_back('{0,1,8'h30,8'h30,8'h11, 1,1,8'h31,8'h44, 0,0,1,8'h30,8'h30,8'h11, 0,8'h00, 0,8'h3C, SI,0});
        vecs.push_back('{0,1,8'h30,8'h30,8'h11, 1,1,8'h31,8'h44, 0,0,1,8'h30,8'h30,8'h11, 1,8'h11, 0,8'h3C, SW,1});
        vecs.push_back('{0,1,8'h30,8'h30,8'h11, 1,1,8'h31,8'h44, 0,0,1,8'h30,8'h30,8'h11, 1,8'h11, 0,8'h3C, SW,2});
        vecs.push_back('{0,1,8'h30,8'h30,8'h11, 1,1,8'h31,8'h44, 0,0,1,8'h30,8'h30,8'h11, 1,8'h11, 0,8'h3C, SW,3});
        vecs.push_back('{0,1,8'h30,8'h30,8'h11, 1,1,8'h31,8'h44, 1,1,1,8'h31,8'h31,8'h44, 0,8'h00, 0,8'h3C, SW,4});
        // HOLDOFF with host still requesting and CPU busy: denied, back to WAIT(1)
        vecs.push_back('{0,1,8'h30,8'h30,8'h11, 1,1,8'h32,8'h55, 0,0,1,8'h30,8'h30,8'h11, 1,8'h11, 0,8'h3C, SH,0});
        // CPU goes idle: unforced grant from WAIT
        vecs.push_back('{0,0,8'h31,8'h00,8'h00, 1,1,8'h32,8'h55, 1,0,1,8'h32,8'h32,8'h55, 0,8'h00, 0,8'h3C, SW,1});
        vecs.push_back('{1,0,8'h31,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h31,8'h00,8'h00, 1,8'h44, 0,8'h3C, SI,0});
        vecs.push_back('{1,0,8'h32,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h32,8'h00,8'h00, 1,8'h55, 0,8'h3C, SI,0});
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("row%0d host_gnt", i),     32'(bus.host_gnt),        32'(v.e_gnt));
        chk($sformatf("row%0d cpu_stall", i),    32'(bus.cpu_stall),       32'(v.e_stall));
        chk($sformatf("row%0d store_to_mem", i), 32'(bus.store_to_mem),    32'(v.e_store));
        chk($sformatf("row%0d data_rd_addr", i), 32'(bus.data_rd_addr),    32'(v.e_rda));
        chk($sformatf("row%0d data_wr_addr", i), 32'(bus.data_wr_addr),    32'(v.e_wra));
        chk($sformatf("row%0d wr_data", i),      32'(bus.datamem_wr_data), 32'(v.e_wd));
        if (v.chk_crd)
            chk($sformatf("row%0d cpu_rd_data", i), 32'(bus.cpu_rd_data), 32'(v.e_crd));
        chk($sformatf("row%0d host_valid", i),   32'(bus.host_valid),      32'(v.e_valid));
        chk($sformatf("row%0d host_rdata", i),   32'(bus.host_rdata),      32'(v.e_rdata));
        chk($sformatf("row%0d state", i),        32'(dbg_state),           32'(v.e_state));
        chk($sformatf("row%0d wait_cnt", i),     32'(dbg_cnt),             32'(v.e_cnt));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        reset = 1'b1;
        // Host requests during reset must not be granted; mux stays on CPU.
        drive(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h10, 8'h99);
        next_cycle();
        next_cycle();
        #2;
        chk("reset host_gnt",     32'(bus.host_gnt),     0);
        chk("reset cpu_stall",    32'(bus.cpu_stall),    0);
        chk("reset store_to_mem", 32'(bus.store_to_mem), 0);
        chk("reset data_rd_addr", 32'(bus.data_rd_addr), 32'h00);
        chk("reset host_valid",   32'(bus.host_valid),   0);
        chk("reset host_rdata",   32'(bus.host_rdata),   0);
        chk("reset state",        32'(dbg_state),        32'(SI));
        chk("reset wait_cnt",     32'(dbg_cnt),          0);

        fill_table();
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) next_cycle();
            drive(vecs[i].ld, vecs[i].st, vecs[i].rda, vecs[i].wra, vecs[i].wd,
                  vecs[i].hreq, vecs[i].hwe, vecs[i].ha, vecs[i].hwd);
            #2;
            check_vec(i, vecs[i]);
        end

        // ---- host withdraws its request while in WAIT ----
        next_cycle();
        drive(1, 0, 8'h40, 8'h00, 8'h00, 1, 0, 8'h41, 8'h00);
        #2;
        chk("drop gnt0", 32'(bus.host_gnt), 0);
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            #2;
            chk($sformatf("drop wait%0d state", k), 32'(dbg_state), 32'(SW));
            chk($sformatf("drop wait%0d cnt", k),   32'(dbg_cnt),   32'(k));
            chk($sformatf("drop wait%0d store", k), 32'(bus.store_to_mem), 0);
        end
        next_cycle();
        bus.host_req = 1'b0;
        #2;
        chk("drop release gnt",   32'(bus.host_gnt),     0);
        chk("drop release store", 32'(bus.store_to_mem), 0);
        next_cycle();
        #2;
        chk("drop idle state", 32'(dbg_state),        32'(SI));
        chk("drop idle cnt",   32'(dbg_cnt),          0);
        chk("drop idle store", 32'(bus.store_to_mem), 0);
        chk("drop idle valid", 32'(bus.host_valid),   0);

        // ---- reset while in WAIT with count 3 ----
        next_cycle();
        drive(1, 0, 8'h40, 8'h00, 8'h00, 1, 0, 8'h41, 8'h00);
        next_cycle();
        next_cycle();
        next_cycle();
        #2;
        chk("rstwait state", 32'(dbg_state), 32'(SW));
        chk("rstwait cnt",   32'(dbg_cnt),   3);
        reset = 1'b1;
        #1;
        chk("rstwait gnt",     32'(bus.host_gnt),     0);
        chk("rstwait stall",   32'(bus.cpu_stall),    0);
        chk("rstwait rd_addr", 32'(bus.data_rd_addr), 32'h40);
        next_cycle();
        reset = 1'b0;
        #2;
        chk("rstwait after state", 32'(dbg_state),      32'(SI));
        chk("rstwait after cnt",   32'(dbg_cnt),        0);
        chk("rstwait after valid", 32'(bus.host_valid), 0);
        chk("rstwait deny0",       32'(bus.host_gnt),   0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            #2;
            chk($sformatf("rstwait deny%0d", k), 32'(bus.host_gnt), 0);
        end
        next_cycle();
        #2;
        chk("rstwait forced gnt",   32'(bus.host_gnt),  1);
        chk("rstwait forced stall", 32'(bus.cpu_stall), 1);
        next_cycle();
        drive(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        #2;
        chk("rstwait holdoff", 32'(dbg_state), 32'(SH));
        chk("rstwait valid",   32'(bus.host_valid), 1);

        // ---- read granted in the cycle before reset ----
        next_cycle();
        drive(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
        #2;
        chk("prerst gnt", 32'(bus.host_gnt), 1);
        next_cycle();
        drive(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        #2;
        chk("prerst valid in reset", 32'(bus.host_valid), 0);
        next_cycle();
        reset = 1'b0;
        #2;
        chk("prerst valid after", 32'(bus.host_valid), 0);
        chk("prerst rdata after", 32'(bus.host_rdata), 0);
        chk("prerst state after", 32'(dbg_state),      32'(SI));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (async read, clocked write) between the CPU load/store path and an external host port (debug/loader/DMA).
- Sits between the CPU core and the instruction/data memory block; drives data_rd_addr, data_wr_addr, datamem_wr_data and store_to_mem.
- The CPU has priority. A wait counter guarantees host forward progress; a holdoff state guarantees CPU forward progress after a forced host grant.

Parameters:
- ADDR_W, 8, data-memory address width.
- DATA_W, 8, data-memory word width.
- STARVE_LIMIT, 4, number of consecutive denied host cycles before a grant is forced (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_ld  in  1  CPU performing a LOAD this cycle.
- cpu_store  in  1  CPU performing a STORE this cycle.
- cpu_rd_addr  in  ADDR_W  CPU load address.
- cpu_wr_addr  in  ADDR_W  CPU store address.
- cpu_wr_data  in  DATA_W  CPU store data.
- cpu_rd_data  out  DATA_W  load data to CPU; combinational pass of datamem_rd_data.
- cpu_stall  out  1  CPU access not serviced this cycle; CPU must hold and retry.
- host_req  in  1  host access request; held until host_gnt.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rdata  out  DATA_W  registered host read data.
- host_valid  out  1  host_rdata valid; one-cycle pulse.
- data_rd_addr  out  ADDR_W  to memory read address.
- data_wr_addr  out  ADDR_W  to memory write address.
- datamem_wr_data  out  DATA_W  to memory write data.
- store_to_mem  out  1  to memory write enable.
- datamem_rd_data  in  DATA_W  from memory (combinational read).

Behaviour:
- cpu_act = cpu_ld | cpu_store.
- States: IDLE, WAIT, HOLDOFF. wait_cnt is a 4-bit register.
- Grant is combinational within the cycle:
  - host_gnt = host_req & !reset & (!cpu_act | (state==WAIT & wait_cnt==STARVE_LIMIT)).
  - A grant caused by the counter condition while cpu_act=1 is a "forced grant".
  - In HOLDOFF, host is granted only if !cpu_act; a grant is never forced in HOLDOFF.
- cpu_stall = host_gnt & cpu_act.
- Memory mux:
  - host_gnt=1: data_rd_addr=host_addr, data_wr_addr=host_addr, datamem_wr_data=host_wdata, store_to_mem=host_we.
  - Otherwise: data_rd_addr=cpu_rd_addr, data_wr_addr=cpu_wr_addr, datamem_wr_data=cpu_wr_data, store_to_mem=cpu_store.
- Transitions:
  - IDLE -> WAIT when host_req & !host_gnt; wait_cnt <= 1.
  - WAIT stays in WAIT while denied; wait_cnt increments and saturates at STARVE_LIMIT.
  - WAIT -> HOLDOFF on a forced grant.
  - WAIT -> IDLE on an unforced grant.
  - Any grant clears wait_cnt.
  - HOLDOFF -> IDLE after exactly one cycle. If host is denied in HOLDOFF, the next state is WAIT with wait_cnt=1.
  - IDLE with a grant, or with no request, stays in IDLE.
- Host read latency: on host_gnt & !host_we, host_rdata <= datamem_rd_data; host_valid=1 the next cycle for exactly one cycle. Host writes produce no host_valid. Memory commits the write on the grant edge.
- Back-to-back: a host holding host_req high after a grant may be granted in consecutive cycles only when the CPU is idle.
- host_req dropped before grant: return to IDLE and clear wait_cnt; no access occurs.
- Host address collision with the CPU on a forced grant has no special case: the CPU is stalled and retries next cycle, and observes the host write.
- Reset:
  - state=IDLE, wait_cnt=0, host_rdata=0, host_valid=0.
  - While reset=1: host_gnt=0, cpu_stall=0, and the memory mux selects the CPU path.
  - Reset mid-wait discards the pending count. A read granted in the cycle before reset produces no host_valid.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_WAIT=2'd1, ST_HOLDOFF=2'd2;
  - default ADDR_W/DATA_W values, shared with the memory block.
- No sub-module is needed. The address/data mux is inline; the FSM, counter and read-capture register live in one module (about 150-200 lines).

Test Plan:
- CPU idle, host read addr 8'h10 with mem[8'h10]=8'hA5 -> host_gnt=1 in the request cycle, cpu_stall=0; host_valid=1 and host_rdata=8'hA5 in the next cycle.
- CPU stores 8'h3C to 8'h20 every cycle while host requests -> host denied for 4 cycles, forced grant on cycle 5 with cpu_stall=1; the next cycle is HOLDOFF with the CPU serviced and host_gnt=0.
- Host write 8'h77 to 8'h05 with the CPU idle, then CPU load from 8'h05 -> store_to_mem=1 with data_wr_addr=8'h05 on the grant; cpu_rd_data=8'h77 afterwards.
- Host holds host_req=1 for 3 cycles with the CPU idle -> 3 consecutive grants; host_valid lags each read by one cycle.
- Assert reset while in WAIT with wait_cnt=3 -> next cycle state=IDLE, wait_cnt=0, host_valid=0; the first grant after release requires the full count again.
- Host drops host_req in WAIT -> returns to IDLE, no store_to_mem pulse, and wait_cnt=0.
